fft_frame_feeder: RTL and testbench
===================================

FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 Parameter N, default 16, points per FFT frame; SHALL be a power of two, at least 4.
REQ-002 Parameter LOG2N, default 4, SHALL equal log2(N).
REQ-003 Parameter SAMPLE_W, default 12, width of a real input sample.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sample_in  input  SAMPLE_W  unsigned real sample.
REQ-007 sample_nd  input  1  new-data strobe; sample_in accepted on each clk edge where high.
REQ-008 fft_ready  input  1  high when the downstream FFT can accept a new frame; low while it reports overflow or busy.
REQ-009 frame_out  output  2*SAMPLE_W  complex word: real in upper SAMPLE_W bits, imaginary (always zero) in lower SAMPLE_W bits.
REQ-010 frame_nd  output  1  frame_out valid; high for exactly N consecutive cycles per frame.
REQ-011 frame_start  output  1  high with the first word of each frame only.
REQ-012 frame_drop  output  1  one-cycle pulse when a completed frame is discarded.
REQ-013 drop_count  output  8  saturating count of dropped frames.

Function
REQ-014 Two N x SAMPLE_W sample banks (ping-pong): one being written, one being read.
REQ-015 Write side: each accepted sample is stored at the write index, which starts at 0 and increments by 1.
REQ-016 Write index wraps from N-1 to 0; that wrap marks the write bank complete.
REQ-017 Read FSM states: IDLE (no frame held), PEND (frame complete, waiting for fft_ready), STREAM (emitting).
REQ-018 IDLE -> PEND when the write bank completes; banks swap in the same edge.
REQ-019 PEND -> STREAM on the first edge with fft_ready high; the first word is registered on that edge.
REQ-020 STREAM emits one word per cycle for N cycles regardless of fft_ready or sample_nd.
REQ-021 STREAM -> IDLE after word N-1, or -> PEND directly if the write bank completes on that same edge (swap, no drop).
REQ-022 Write bank completes while FSM is PEND or STREAM (excluding REQ-021 case): completed frame discarded, frame_drop pulses, drop_count increments unless at 255; writing continues at index 0 into the same bank.
REQ-023 Latency: last sample of a frame accepted at edge t with FSM IDLE and fft_ready high -> first frame_out word valid after edge t+1.
REQ-024 Read order word k (k = 0..N-1) is bank address bitrev(k) over LOG2N bits when the macro of REQ-030 is defined.
REQ-025 frame_out real part equals stored sample unmodified; lower SAMPLE_W bits are zero.
REQ-026 frame_out SHALL be zero whenever frame_nd is low.

Reset
REQ-027 On reset_n low: frame_out=0, frame_nd=0, frame_start=0, frame_drop=0, drop_count=0, FSM=IDLE, write index=0, bank select=0.
REQ-028 Reset asserted mid-frame (write or stream) discards all partial and pending data; bank contents need not be cleared.
REQ-029 After reset release, the first accepted sample is index 0 of a new frame.

Configuration
REQ-030 Macro FFT_FEEDER_BITREV_EN defined: output in bit-reversed (radix-2 DIT input) order per REQ-024.
REQ-031 Macro undefined: word k is bank address k (natural order, for DIF cores); bit-reverse logic not synthesised.

Structure
REQ-032 Shared package fft_pkg holds N, LOG2N, SAMPLE_W defaults, the complex word width, and the read FSM state encoding.
REQ-033 One sub-module, fft_bitrev_index (combinational LOG2N-bit reversal), instantiated only under FFT_FEEDER_BITREV_EN.

Verification
REQ-034 BITREV_EN, fft_ready=1, samples 50,115,43,20,2,13,115,20,200,46,80,92,73,62,900,1 -> real parts 50,200,2,73,43,80,115,900,115,46,13,62,20,92,20,1; frame_start on first only; imaginary 0.
REQ-035 Macro undefined, same 16 samples -> output in input order 50..1, 16 consecutive frame_nd cycles.
REQ-036 fft_ready=0 while frame 1 completes, 16 more samples written -> frame 2 dropped, frame_drop one pulse, drop_count=1; fft_ready=1 then streams frame 1.
REQ-037 Continuous sample_nd every cycle for 4 frames, fft_ready=1 -> 4 frames back-to-back via REQ-021, no drops.
REQ-038 reset_n low at 7th sample and again mid-stream -> all outputs 0 next edge; next 16 samples form a correct frame.
REQ-039 300 forced drops -> drop_count holds at 255.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame feeder.
// Holds the default frame geometry (N, LOG2N, SAMPLE_W), the complex output
// word width and the read-side FSM state encoding.
package fft_pkg;

  localparam int unsigned FFT_N        = 16;
  localparam int unsigned FFT_LOG2N    = 4;
  localparam int unsigned FFT_SAMPLE_W = 12;
  // Complex word: real in the upper half, imaginary in the lower half.
  localparam int unsigned FFT_CPLX_W   = 2 * FFT_SAMPLE_W;

  // IDLE: no frame held; PEND: frame complete, waiting for fft_ready;
  // STREAM: emitting the held frame one word per cycle.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPend   = 2'd1,
    StStream = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fft_bitrev_index.sv
// Combinational bit reversal of a W-bit index (radix-2 DIT input ordering).
// Ports:
//   idx  - natural-order index
//   rev  - idx with its bit order reversed
module fft_bitrev_index #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] idx,
  output logic [W-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int i = 0; i < W; i++) begin
      rev[i] = idx[W-1-i];
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer between a real sample stream and an FFT core.
// Samples are written into one bank while the other, once complete, is streamed
// out as N consecutive complex words (imaginary part zero). A frame that
// completes while the previous one is still held is discarded and counted.
// Configuration macro: FFT_FEEDER_BITREV_EN -- when defined the frame is read in
// bit-reversed address order; otherwise in natural order.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   sample_in     - unsigned real sample, accepted when sample_nd is high
//   sample_nd     - new-sample strobe
//   fft_ready     - downstream FFT can accept a new frame
//   frame_out     - {real, 0} complex word, zero while frame_nd is low
//   frame_nd      - frame_out valid, N consecutive cycles per frame
//   frame_start   - marks the first word of a frame
//   frame_drop    - one-cycle pulse when a completed frame is discarded
//   drop_count    - saturating count of dropped frames
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int unsigned N        = FFT_N,
  parameter int unsigned LOG2N    = FFT_LOG2N,
  parameter int unsigned SAMPLE_W = FFT_SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_nd,
  input  logic                  fft_ready,
  output logic [2*SAMPLE_W-1:0] frame_out,
  output logic                  frame_nd,
  output logic                  frame_start,
  output logic                  frame_drop,
  output logic [7:0]            drop_count
);

  // Both banks in one array, addressed as {bank, index}.
  logic [SAMPLE_W-1:0] mem [2*N];

  rd_state_e        state;
  logic [LOG2N-1:0] wr_idx;
  logic [LOG2N-1:0] rd_idx;
  logic             wr_bank;
  logic             rd_bank;

  logic             wr_last;
  logic             rd_last;
  logic             swap;
  logic [LOG2N-1:0] rd_ptr;
  logic [LOG2N-1:0] rd_addr;
  logic [SAMPLE_W-1:0] rd_word;

  always_comb begin
    wr_last = sample_nd && (wr_idx == LOG2N'(N - 1));
    rd_last = (state == StStream) && (rd_idx == LOG2N'(N - 1));
    // A completed write bank is taken over only if the read side is free now,
    // or frees up on this very edge (back-to-back frames).
    swap    = wr_last && ((state == StIdle) || rd_last);
    // Word 0 is fetched on the PEND -> STREAM edge.
    rd_ptr  = (state == StStream) ? rd_idx : '0;
  end

`ifdef FFT_FEEDER_BITREV_EN
  fft_bitrev_index #(
    .W (LOG2N)
  ) u_bitrev (
    .idx (rd_ptr),
    .rev (rd_addr)
  );
`else
  assign rd_addr = rd_ptr;
`endif

  assign rd_word = mem[{rd_bank, rd_addr}];

  // Sample storage is not reset; stale contents are never read out.
  always_ff @(posedge clk) begin
    if (sample_nd) begin
      mem[{wr_bank, wr_idx}] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      wr_idx      <= '0;
      rd_idx      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      frame_out   <= '0;
      frame_nd    <= 1'b0;
      frame_start <= 1'b0;
      frame_drop  <= 1'b0;
      drop_count  <= '0;
    end else begin
      frame_out   <= '0;
      frame_nd    <= 1'b0;
      frame_start <= 1'b0;
      frame_drop  <= 1'b0;

      if (sample_nd) begin
        wr_idx <= wr_idx + 1'b1;
      end

      if (swap) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end else if (wr_last) begin
        // Read side busy: discard, keep refilling the same bank from index 0.
        frame_drop <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end

      unique case (state)
        StIdle: begin
          if (swap) begin
            state <= StPend;
          end
        end
        StPend: begin
          if (fft_ready) begin
            state       <= StStream;
            rd_idx      <= LOG2N'(1);
            frame_out   <= {rd_word, {SAMPLE_W{1'b0}}};
            frame_nd    <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        StStream: begin
          frame_out <= {rd_word, {SAMPLE_W{1'b0}}};
          frame_nd  <= 1'b1;
          rd_idx    <= rd_idx + 1'b1;
          if (rd_last) begin
            state <= swap ? StPend : StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: directed frames plus randomized
// sample/ready traffic compared each cycle against a frame-level reference model.
module tb_fft_frame_feeder;

  localparam int N  = 16;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [SW-1:0] sample_in;
  logic          sample_nd;
  logic          fft_ready;
  logic [2*SW-1:0] frame_out;
  logic          frame_nd;
  logic          frame_start;
  logic          frame_drop;
  logic [7:0]    drop_count;

  always #5 clk = ~clk;

  fft_frame_feeder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_in   (sample_in),
    .sample_nd   (sample_nd),
    .fft_ready   (fft_ready),
    .frame_out   (frame_out),
    .frame_nd    (frame_nd),
    .frame_start (frame_start),
    .frame_drop  (frame_drop),
    .drop_count  (drop_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a partially collected frame, at most one held frame, and
  // the position of the next word to emit from it (-1 while waiting).
  logic [SW-1:0] m_wbuf [N];
  logic [SW-1:0] m_held [N];
  int            m_wcnt;
  bit            m_have;
  int            m_pos;
  int            m_drops;
  logic [2*SW-1:0] e_out;
  bit            e_nd, e_start, e_drop;
  logic [SW-1:0] cap [$];

  function automatic int order(input int k);
    int r;
`ifdef FFT_FEEDER_BITREV_EN
    r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((k >> b) & 1);
`else
    r = k;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_wcnt = 0; m_have = 0; m_pos = -1; m_drops = 0;
  endtask

  task automatic model_edge(input bit nd, input logic [SW-1:0] s, input bit rdy);
    e_out = '0; e_nd = 0; e_start = 0; e_drop = 0;
    if (m_have && m_pos >= 0) begin
      e_out = {m_held[order(m_pos)], 12'h000};
      e_nd  = 1;
      m_pos++;
      if (m_pos == N) begin
        m_have = 0;
        m_pos  = -1;
      end
    end else if (m_have && rdy) begin
      e_out   = {m_held[order(0)], 12'h000};
      e_nd    = 1;
      e_start = 1;
      m_pos   = 1;
    end
    if (nd) begin
      m_wbuf[m_wcnt] = s;
      m_wcnt++;
      if (m_wcnt == N) begin
        m_wcnt = 0;
        if (!m_have) begin
          m_held = m_wbuf;
          m_have = 1;
          m_pos  = -1;
        end else begin
          e_drop = 1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  endtask

  task automatic step(input bit nd, input logic [SW-1:0] s, input bit rdy);
    @(negedge clk);
    sample_nd = nd;
    sample_in = s;
    fft_ready = rdy;
    @(posedge clk);
    model_edge(nd, s, rdy);
    #1;
    check_val("frame_out", 32'(frame_out), 32'(e_out));
    check_val("frame_nd", 32'(frame_nd), 32'(e_nd));
    check_val("frame_start", 32'(frame_start), 32'(e_start));
    check_val("frame_drop", 32'(frame_drop), 32'(e_drop));
    check_val("drop_count", 32'(drop_count), 32'(m_drops));
    if (frame_nd) cap.push_back(frame_out[2*SW-1:SW]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_nd = 0;
    reset_n   = 0;
    #1;
    check_val("rst_frame_out", 32'(frame_out), 32'd0);
    check_val("rst_frame_nd", 32'(frame_nd), 32'd0);
    check_val("rst_frame_start", 32'(frame_start), 32'd0);
    check_val("rst_frame_drop", 32'(frame_drop), 32'd0);
    check_val("rst_drop_count", 32'(drop_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  int dir_in [16]     = '{50, 115, 43, 20, 2, 13, 115, 20, 200, 46, 80, 92, 73, 62, 900, 1};
  int dir_bitrev [16] = '{50, 200, 2, 73, 43, 80, 115, 900, 115, 46, 13, 62, 20, 92, 20, 1};

  initial begin
    reset_n   = 0;
    sample_nd = 0;
    sample_in = '0;
    fft_ready = 0;
    model_reset();
    #12;
    do_reset();

    // Directed frame, compared against the literal expected order.
    cap.delete();
    for (int i = 0; i < N; i++) step(1, SW'(dir_in[i]), 1);
    for (int i = 0; i < 20; i++) step(0, '0, 1);
    check_val("dir_word_count", 32'(cap.size()), 32'd16);
    for (int k = 0; k < N && k < cap.size(); k++) begin
`ifdef FFT_FEEDER_BITREV_EN
      check_val("dir_word", 32'(cap[k]), 32'(dir_bitrev[k]));
`else
      check_val("dir_word", 32'(cap[k]), 32'(dir_in[k]));
`endif
    end

    // Second frame completes while the first is held: one drop.
    for (int i = 0; i < 2 * N; i++) step(1, SW'($urandom), 0);
    for (int i = 0; i < 25; i++) step(0, '0, 1);
    check_val("drop_after_hold", 32'(drop_count), 32'd1);

    // Continuous samples, four back-to-back frames.
    for (int i = 0; i < 4 * N; i++) step(1, SW'($urandom), 1);
    for (int i = 0; i < 20; i++) step(0, '0, 1);
    check_val("drop_after_b2b", 32'(drop_count), 32'd1);

    // Reset at the 7th sample, then again mid-stream.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, SW'($urandom), 1);
    do_reset();
    for (int i = 0; i < N; i++) step(1, SW'($urandom), 1);
    for (int i = 0; i < 20; i++) step(0, '0, 1);
    for (int i = 0; i < N; i++) step(1, SW'($urandom), 1);
    for (int i = 0; i < 6; i++) step(0, '0, 1);
    do_reset();
    for (int i = 0; i < N; i++) step(1, SW'($urandom), 1);
    for (int i = 0; i < 20; i++) step(0, '0, 1);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 301 * N; i++) step(1, SW'($urandom), 0);
    check_val("drop_saturated", 32'(drop_count), 32'd255);
    for (int i = 0; i < 20; i++) step(0, '0, 1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, SW'($urandom), ($urandom % 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
